// File: rtl/mul_pkg.sv
// ----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential nibble multiplier.
//   - mul_state_t  : controller states (IDLE, RUN, DONE)
//   - NIBBLE_W     : digit width consumed per cycle
//   - nibble_count : number of digits in a given operand width
//   - SIGNED_MODE  : 1 when the MUL_SIGNED_EN macro is defined (two's-complement
//                    operands), 0 otherwise (unsigned operands)
// ----------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int NIBBLE_W = 4;

`ifdef MUL_SIGNED_EN
    localparam logic SIGNED_MODE = 1'b1;
`else
    localparam logic SIGNED_MODE = 1'b0;
`endif

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_pp_gen.sv
// ----------------------------------------------------------------------------
// nibble_pp_gen
// Combinational operand-by-digit partial product.
// Ports:
//   op_a       in  WIDTH    multiplicand
//   nibble     in  4        multiplier digit for this cycle
//   top_nibble in  1        digit is the most significant one of op_b
//   pp         out WIDTH+4  op_a * digit
// Signedness follows MUL_SIGNED_EN (via mul_pkg::SIGNED_MODE): when set, op_a
// is sign-extended and the top digit is read as -8..7; otherwise everything is
// zero-extended.
// ----------------------------------------------------------------------------
module nibble_pp_gen #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [3:0]       nibble,
    input  logic             top_nibble,
    output logic [WIDTH+3:0] pp
);
    import mul_pkg::*;

    logic             w_a_fill;
    logic             w_d_fill;
    logic [WIDTH+3:0] w_a_ext;
    logic [WIDTH+3:0] w_d_ext;

    // Both factors are extended to the full product width so a plain
    // modulo multiply yields the correct two's-complement low bits; the
    // true product always fits in WIDTH+4 bits.
    assign w_a_fill = SIGNED_MODE & op_a[WIDTH-1];
    assign w_d_fill = SIGNED_MODE & top_nibble & nibble[3];
    assign w_a_ext  = {{4{w_a_fill}}, op_a};
    assign w_d_ext  = {{WIDTH{w_d_fill}}, nibble};
    assign pp       = w_a_ext * w_d_ext;

endmodule

// File: rtl/seq_nibble_multiplier.sv
// ----------------------------------------------------------------------------
// seq_nibble_multiplier
// Multi-cycle multiplier: consumes op_b one 4-bit digit per cycle and
// accumulates shifted partial products into a 2*WIDTH-bit product.
// Ports:
//   clk, arst_n                 clock, async active-low reset
//   start_valid/start_ready     operand handshake (op_a, op_b latched on accept)
//   result_valid/result_ready   product handshake
//   result                      2*WIDTH-bit product, held until the next one
//   busy                        high in RUN or DONE
// Build option: define MUL_SIGNED_EN for a signed (two's-complement) product;
// undefined gives an unsigned product. Timing is the same in both builds.
// ----------------------------------------------------------------------------
module seq_nibble_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);
    import mul_pkg::*;

    localparam int NCNT  = nibble_count(WIDTH);
    localparam int CNT_W = $clog2(NCNT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCNT - 1);

    mul_state_t           r_state;
    mul_state_t           w_next_state;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_result;

    logic [WIDTH+3:0]     w_pp;
    logic                 w_pp_fill;
    logic [2*WIDTH-1:0]   w_pp_ext;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_top;

    assign w_top = (r_count == LAST);

    nibble_pp_gen #(
        .WIDTH(WIDTH)
    ) u_pp_gen (
        .op_a       (r_op_a),
        .nibble     (r_mplier[NIBBLE_W-1:0]),
        .top_nibble (w_top),
        .pp         (w_pp)
    );

    // Extend the partial product to accumulator width and place it at digit
    // position k (k*4 bits, hence the two appended zero bits).
    assign w_pp_fill  = SIGNED_MODE & w_pp[WIDTH+3];
    assign w_pp_ext   = {{(WIDTH-4){w_pp_fill}}, w_pp};
    assign w_addend   = w_pp_ext << {r_count, 2'b00};
    assign w_acc_next = r_acc + w_addend;

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fixed-length RUN, then wait in DONE for the consumer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_valid)  w_next_state = RUN;
            RUN:     if (w_top)        w_next_state = DONE;
            DONE:    if (result_ready) w_next_state = IDLE;
            default:                   w_next_state = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then shift the multiplier down one
    // digit per RUN cycle so the current digit is always in the low nibble.
    // The finished sum is copied to r_result so it survives the next accept.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_op_a   <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_op_a   <= op_a;
                        r_mplier <= op_b;
                        r_count  <= '0;
                        r_acc    <= '0;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> NIBBLE_W;
                    r_count  <= r_count + 1'b1;
                    if (w_top) begin
                        r_result <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign start_ready  = (r_state == IDLE);
    assign result_valid = (r_state == DONE);
    assign busy         = (r_state != IDLE);
    assign result       = r_result;

endmodule

// File: doc/seq_nibble_multiplier.md
# seq_nibble_multiplier

- Multi-cycle signed multiply unit for the ALU datapath.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake and consumes the multiplier 4 bits per cycle.
- Each cycle, one operand-by-nibble partial product is formed combinationally and accumulated into a 2*WIDTH-bit product.
- Presents the full product on a valid/ready result port.

## Interface
- WIDTH, 16, operand width; must be a multiple of 4 and at least 8
- clk  in  1  system clock, rising edge
- arst_n  in  1  reset, asynchronous assert, active-low
- start_valid  in  1  operand pair offered
- start_ready  out  1  unit can accept operands
- op_a  in  WIDTH  multiplicand
- op_b  in  WIDTH  multiplier
- result_valid  out  1  product available
- result_ready  in  1  consumer takes the product
- result  out  2*WIDTH  product a*b
- busy  out  1  high in RUN or DONE

## Operation
- One clock; reset is asynchronous and active-low.
- States: IDLE, RUN, DONE.
- Reset state: IDLE, accumulator 0, nibble counter 0.
- Reset output values: start_ready=1, result_valid=0, result=0, busy=0.
- IDLE:
  - start_ready=1.
  - On start_valid, latch op_a and op_b, clear the accumulator, set the counter to 0, and go to RUN.
- RUN:
  - Each cycle, form pp = op_a × nibble k, where k is the counter and nibble k = op_b[4k+3:4k].
  - pp is WIDTH+4 bits, with op_a sign-extended.
  - Add pp shifted left 4k bits to the accumulator; arithmetic is modulo 2^(2*WIDTH).
  - Increment k. After nibble WIDTH/4−1 is added, go to DONE.
- Nibble signedness (signed build):
  - Nibbles 0..WIDTH/4−2 are unsigned digits.
  - The top nibble is a two's-complement digit, −8..7; its pp is subtracted-equivalent.
- DONE:
  - result_valid=1 and result = accumulator.
  - On result_ready, go to IDLE; result_valid drops the next cycle.
- result holds its last value after DONE until the next product completes.
- There is no overlap: start_ready=0 in RUN and DONE, so a start_valid offered while busy is ignored until IDLE.
- Reset mid-RUN or mid-DONE: immediate return to reset values. The partial product is discarded and no result_valid is produced.
- Zero operands take the same cycle count; there is no early termination.

## Timing
- Accept edge: the rising edge with start_valid && start_ready.
- RUN lasts exactly WIDTH/4 cycles; this is 4 for WIDTH=16.
- result_valid rises WIDTH/4 edges after the accept edge.
- Best-case throughput: one product per WIDTH/4+2 cycles, with result_ready held high.
- DONE edge with result_ready=1 → IDLE. The next accept can occur on the following edge.
- The partial-product path is combinational within one cycle: WIDTH×4 multiplier plus a 2*WIDTH-bit adder.
- result, result_valid, start_ready and busy are registered or state-decoded only. They have no combinational path from inputs.

## Configuration
- MUL_SIGNED_EN defined:
  - op_a is two's-complement and is sign-extended in pp.
  - The top nibble of op_b is weighted −8·2^(4(n−1)).
  - result is the signed product.
- MUL_SIGNED_EN undefined:
  - Both operands are unsigned and all nibbles are unsigned digits.
  - op_a is zero-extended.
  - result is the unsigned product.
- Cycle timing is identical in both builds.

## Structure
- Shared package mul_pkg holds:
  - the state enum type mul_state_t (IDLE, RUN, DONE);
  - the constant NIBBLE_W = 4;
  - the function nibble_count(width) = width/4.
- Sub-module nibble_pp_gen:
  - Inputs: op_a, the 4-bit nibble, and a top_nibble flag.
  - Output: the WIDTH+4-bit partial product, with signedness per MUL_SIGNED_EN.
  - The controller, accumulator and handshake stay in the top.

## Test plan
- Signed build, WIDTH=16. op_a=3, op_b=5 → result=0x0000000F. result_valid asserts exactly 4 edges after accept.
- op_a=−7 (0xFFF9), op_b=3 → result=0xFFFFFFEB. op_a=0x8000, op_b=0x8000 → result=0x40000000.
- op_a=0x7FFF, op_b=0x8000 → result=0xC0008000. op_a=0x7FFF, op_b=0x7FFF → result=0x3FFF0001.
- Backpressure:
  - Hold result_ready=0 for 3 cycles in DONE: result and result_valid stay stable, and start_ready stays 0.
  - A start_valid pulse during RUN is not accepted.
- Assert arst_n low on the 2nd RUN cycle → outputs are at reset values immediately, with no result_valid. A new operation after release computes correctly.
- Unsigned build (MUL_SIGNED_EN undefined). op_a=0xFFFF, op_b=0xFFFF → result=0xFFFE0001. Back-to-back ops with result_ready tied high → one accept every 6 cycles.
